// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the PC-write and instruction-fetch stages.
package ins_fetch_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam int unsigned ILEN_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ins_fetch.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over req/ack
// and hands words to the decoder over valid/ready, honouring execute redirects.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_pc_w_op,
    input  logic [31:0] reg_pc_w_val,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    output logic        pc_misalign
);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] ins_data_q, ins_data_d;
    logic [31:0] ins_pc_q, ins_pc_d;
    logic        misalign_q, misalign_d;
    logic        mem_req_s, ins_valid_s;

    logic redirect_act, redir_ok, redir_bad, fetch_done;

    // A halted fetch unit ignores redirects; only reset revives it.
    assign redirect_act = reg_pc_w_op && (state_q != S_HALT);
    assign redir_ok     = redirect_act &&  is_word_aligned(reg_pc_w_val);
    assign redir_bad    = redirect_act && !is_word_aligned(reg_pc_w_val);
    assign fetch_done   = (state_q == S_REQ) && mem_ack && !redirect_act;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirects override every normal transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (redir_bad) state_d = S_HALT;
                else           state_d = S_REQ;
            end
            S_REQ: begin
                if (redir_bad)      state_d = S_HALT;
                else if (redir_ok)  state_d = mem_ack ? S_REQ : S_FLUSH;
                else if (mem_ack)   state_d = S_HOLD;
                else                state_d = S_REQ;
            end
            S_HOLD: begin
                if (redir_bad)      state_d = S_HALT;
                else if (redir_ok)  state_d = S_REQ;
                else if (ins_ready) state_d = S_REQ;
                else                state_d = S_HOLD;
            end
            S_FLUSH: begin
                if (redir_bad)    state_d = S_HALT;
                else if (mem_ack) state_d = S_REQ;
                else              state_d = S_FLUSH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the current state
    always_comb begin
        mem_req_s   = 1'b0;
        ins_valid_s = 1'b0;
        case (state_q)
            S_REQ, S_FLUSH: begin
                mem_req_s   = 1'b1;
                ins_valid_s = 1'b0;
            end
            S_HOLD: begin
                mem_req_s   = 1'b0;
                ins_valid_s = 1'b1;
            end
            default: begin
                mem_req_s   = 1'b0;
                ins_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: PC, request address, instruction buffer, sticky flag
    always_comb begin
        if (redir_ok) begin
            pc_d = reg_pc_w_val;
        end else if (fetch_done) begin
            pc_d = pc_q + 32'(ILEN_BYTES);
        end else begin
            pc_d = pc_q;
        end

        // The address is latched on entry to S_REQ; a flush keeps the stale one.
        if (state_d == S_REQ) begin
            mem_addr_d = pc_d;
        end else begin
            mem_addr_d = mem_addr_q;
        end

        if (fetch_done) begin
            ins_data_d = mem_rdata;
            ins_pc_d   = pc_q;
        end else begin
            ins_data_d = ins_data_q;
            ins_pc_d   = ins_pc_q;
        end

        misalign_d = misalign_q | redir_bad;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            mem_addr_q <= 32'h0000_0000;
            ins_data_q <= 32'h0000_0000;
            ins_pc_q   <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            ins_data_q <= ins_data_d;
            ins_pc_q   <= ins_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign mem_req     = mem_req_s;
    assign mem_addr    = mem_addr_q;
    assign ins_valid   = ins_valid_s;
    assign ins_data    = ins_data_q;
    assign ins_pc      = ins_pc_q;
    assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed scenarios plus a randomized run
// scored against a program-order model of the accepted instruction stream.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst_n, reg_pc_w_op, mem_ack, ins_ready;
    logic [31:0] reg_pc_w_val, mem_rdata;
    logic        mem_req, ins_valid, pc_misalign;
    logic [31:0] mem_addr, ins_data, ins_pc;

    logic        w_rst_n, w_op, w_mem_ack, w_ins_ready;
    logic [31:0] w_val, w_mem_rdata;
    logic        w_mem_req, w_ins_valid, w_misalign;
    logic [31:0] w_mem_addr, w_ins_data, w_ins_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ins_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .reg_pc_w_op(reg_pc_w_op), .reg_pc_w_val(reg_pc_w_val),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data), .ins_pc(ins_pc),
        .pc_misalign(pc_misalign)
    );

    ins_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(w_rst_n), .reg_pc_w_op(w_op), .reg_pc_w_val(w_val),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
        .ins_valid(w_ins_valid), .ins_ready(w_ins_ready), .ins_data(w_ins_data), .ins_pc(w_ins_pc),
        .pc_misalign(w_misalign)
    );

    // Memory contents as a function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; reg_pc_w_op = 1'b0; reg_pc_w_val = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0; ins_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_req !== 1'b0)      begin failures++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h0)    begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        checks++; if (ins_valid !== 1'b0)    begin failures++; $display("FAIL rst_valid got=%b exp=0", ins_valid); end
        checks++; if (ins_data !== 32'h0 || ins_pc !== 32'h0) begin failures++; $display("FAIL rst_ins got=%h/%h exp=0/0", ins_data, ins_pc); end
        checks++; if (pc_misalign !== 1'b0)  begin failures++; $display("FAIL rst_misalign got=%b exp=0", pc_misalign); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%b@%h exp=1@0", mem_req, mem_addr); end
    endtask

    // Continues from test_reset: state is requesting address 0.
    task automatic test_sequential();
        logic [31:0] exp;
        ins_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = 32'(k) * 32'd4;
            checks++; if (mem_req !== 1'b1 || mem_addr !== exp) begin failures++; $display("FAIL seq_req got=%b@%h exp=1@%h", mem_req, mem_addr, exp); end
            step();
            checks++; if (mem_req !== 1'b1 || mem_addr !== exp || ins_valid !== 1'b0) begin failures++; $display("FAIL seq_hold_addr got=%b@%h v=%b exp=1@%h v=0", mem_req, mem_addr, ins_valid, exp); end
            mem_ack = 1'b1; mem_rdata = memf(exp);
            step();
            mem_ack = 1'b0;
            checks++; if (ins_valid !== 1'b1 || ins_pc !== exp || ins_data !== memf(exp) || mem_req !== 1'b0) begin
                failures++; $display("FAIL seq_present got=v%b pc=%h d=%h req=%b exp=v1 pc=%h d=%h req=0", ins_valid, ins_pc, ins_data, mem_req, exp, memf(exp)); end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013; ins_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            checks++; if (ins_valid !== 1'b1 || ins_data !== 32'h0000_0013 || ins_pc !== 32'h0 || mem_req !== 1'b0) begin
                failures++; $display("FAIL bp_hold got=v%b d=%h pc=%h req=%b exp=v1 d=00000013 pc=0 req=0", ins_valid, ins_data, ins_pc, mem_req); end
            step();
        end
        mem_ack = 1'b0; ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || ins_valid !== 1'b0) begin failures++; $display("FAIL bp_next got=%b@%h v=%b exp=1@4 v=0", mem_req, mem_addr, ins_valid); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        ins_ready = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            mem_ack = 1'b1; mem_rdata = memf(mem_addr);
            step();
            mem_ack = 1'b0;
            step();
        end
        checks++; if (mem_addr !== 32'h8 || mem_req !== 1'b1) begin failures++; $display("FAIL fl_pre got=%b@%h exp=1@8", mem_req, mem_addr); end
        reg_pc_w_op = 1'b1; reg_pc_w_val = 32'h100;
        step();
        reg_pc_w_op = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || ins_valid !== 1'b0) begin failures++; $display("FAIL fl_stale got=%b@%h v=%b exp=1@8 v=0", mem_req, mem_addr, ins_valid); end
            step();
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || ins_valid !== 1'b0) begin failures++; $display("FAIL fl_new got=%b@%h v=%b exp=1@100 v=0", mem_req, mem_addr, ins_valid); end
        mem_ack = 1'b1; mem_rdata = memf(32'h100);
        step();
        mem_ack = 1'b0;
        checks++; if (ins_valid !== 1'b1 || ins_pc !== 32'h100 || ins_data !== memf(32'h100)) begin failures++; $display("FAIL fl_present got=v%b pc=%h d=%h exp=v1 pc=100 d=%h", ins_valid, ins_pc, ins_data, memf(32'h100)); end
    endtask

    // Continues from test_redirect_flush: an instruction at 0x100 is buffered.
    task automatic test_redirect_handshake();
        ins_ready = 1'b1; reg_pc_w_op = 1'b1; reg_pc_w_val = 32'h200;
        step();
        reg_pc_w_op = 1'b0;
        checks++; if (ins_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin failures++; $display("FAIL hs_redir got=v%b %b@%h exp=v0 1@200", ins_valid, mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = memf(32'h200);
        step();
        mem_ack = 1'b0;
        checks++; if (ins_valid !== 1'b1 || ins_pc !== 32'h200 || ins_data !== memf(32'h200)) begin failures++; $display("FAIL hs_present got=v%b pc=%h d=%h exp=v1 pc=200 d=%h", ins_valid, ins_pc, ins_data, memf(32'h200)); end
    endtask

    task automatic test_misalign();
        do_reset();
        step();
        reg_pc_w_op = 1'b1; reg_pc_w_val = 32'h102;
        step();
        checks++; if (pc_misalign !== 1'b1 || mem_req !== 1'b0 || ins_valid !== 1'b0) begin failures++; $display("FAIL mis_set got=f%b req=%b v=%b exp=f1 req=0 v=0", pc_misalign, mem_req, ins_valid); end
        for (int i = 0; i < 10; i++) begin
            reg_pc_w_op = 1'($urandom_range(0, 1)); reg_pc_w_val = $urandom & 32'h0000_FFFC;
            mem_ack = 1'($urandom_range(0, 1)); ins_ready = 1'($urandom_range(0, 1));
            step();
            checks++; if (pc_misalign !== 1'b1 || mem_req !== 1'b0 || ins_valid !== 1'b0) begin failures++; $display("FAIL mis_halt got=f%b req=%b v=%b exp=f1 req=0 v=0", pc_misalign, mem_req, ins_valid); end
        end
        reg_pc_w_op = 1'b0; mem_ack = 1'b0; rst_n = 1'b0;
        step();
        checks++; if (pc_misalign !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL mis_clear got=f%b %b@%h exp=f0 0@0", pc_misalign, mem_req, mem_addr); end
        rst_n = 1'b1;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL mis_restart got=%b@%h exp=1@0", mem_req, mem_addr); end
    endtask

    task automatic test_wrap();
        w_rst_n = 1'b0; w_mem_ack = 1'b0; w_ins_ready = 1'b1;
        step();
        w_rst_n = 1'b1;
        step();
        checks++; if (w_mem_req !== 1'b1 || w_mem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first got=%b@%h exp=1@fffffffc", w_mem_req, w_mem_addr); end
        w_mem_ack = 1'b1; w_mem_rdata = memf(32'hFFFF_FFFC);
        step();
        w_mem_ack = 1'b0;
        checks++; if (w_ins_valid !== 1'b1 || w_ins_pc !== 32'hFFFF_FFFC || w_ins_data !== memf(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_present got=v%b pc=%h exp=v1 pc=fffffffc", w_ins_valid, w_ins_pc); end
        step();
        checks++; if (w_mem_req !== 1'b1 || w_mem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%b@%h exp=1@0", w_mem_req, w_mem_addr); end
    endtask

    // Accepted instructions must run sequentially from the last redirect target.
    task automatic test_random();
        logic [31:0] exp_pc, p_addr, p_data, p_pc;
        logic        p_req, p_ack, p_valid, p_ready, p_op;
        int          hs;
        do_reset();
        exp_pc = 32'h0; hs = 0;
        p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_op = 1'b0;
        p_addr = 32'h0; p_data = 32'h0; p_pc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (p_req && !p_ack && mem_req) begin
                checks++; if (mem_addr !== p_addr) begin failures++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", c, mem_addr, p_addr); end
            end
            if (p_valid && !p_ready && !p_op) begin
                checks++; if (ins_valid !== 1'b1 || ins_data !== p_data || ins_pc !== p_pc) begin failures++; $display("FAIL rnd_ins_stable cyc=%0d got=v%b %h@%h exp=v1 %h@%h", c, ins_valid, ins_data, ins_pc, p_data, p_pc); end
            end
            checks++; if (pc_misalign !== 1'b0) begin failures++; $display("FAIL rnd_misalign cyc=%0d got=%b exp=0", c, pc_misalign); end

            ins_ready    = ($urandom_range(0, 99) < 70);
            reg_pc_w_op  = ($urandom_range(0, 99) < 6);
            reg_pc_w_val = $urandom & 32'h0000_FFFC;
            mem_ack      = mem_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            mem_rdata    = (mem_req && mem_ack) ? memf(mem_addr) : $urandom;

            if (reg_pc_w_op) begin
                exp_pc = reg_pc_w_val;
            end else if (ins_valid && ins_ready) begin
                checks++; if (ins_pc !== exp_pc || ins_data !== memf(exp_pc)) begin failures++; $display("FAIL rnd_stream cyc=%0d got=%h@%h exp=%h@%h", c, ins_data, ins_pc, memf(exp_pc), exp_pc); end
                exp_pc = exp_pc + 32'd4;
                hs++;
            end
            p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr;
            p_valid = ins_valid; p_ready = ins_ready; p_op = reg_pc_w_op;
            p_data = ins_data; p_pc = ins_pc;
            step();
        end
        reg_pc_w_op = 1'b0;
        checks++; if (hs < 200) begin failures++; $display("FAIL rnd_progress got=%0d exp>=200", hs); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        w_rst_n = 1'b0; w_op = 1'b0; w_val = 32'h0; w_mem_ack = 1'b0;
        w_mem_rdata = 32'h0; w_ins_ready = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_flush();
        test_redirect_handshake();
        test_misalign();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
